// File: rtl/adder_arb_pkg.sv
// Shared types and default parameters for the adder arbiter and its round-robin helper.
package adder_arb_pkg;

  localparam int ARB_NUM_REQ_DEF = 4;
  localparam int ARB_WIDTH_DEF   = 16;
  localparam int ARB_ADD_LAT_DEF = 4;

  // Wide enough for the largest supported requester count (8).
  localparam int ARB_ID_W = 3;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [ARB_ID_W-1:0] id;
  } arb_tag_t;

endpackage

// File: rtl/adder_arbiter_rr.sv
// Combinational round-robin pick: the search starts one past the last granted index and wraps.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NUM_REQ = ARB_NUM_REQ_DEF,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_next_ptr,
  output logic               o_any
);

  always_comb begin
    o_grant    = '0;
    o_next_ptr = i_ptr;
    o_any      = 1'b0;
    // Candidate i sits at distance off from the pointer; nearest requesting candidate wins.
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!o_any && i_req[i] && (int'(i_ptr) == ((i - off + NUM_REQ) % NUM_REQ))) begin
          o_grant[i] = 1'b1;
          o_next_ptr = IDW'(i);
          o_any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one pipelined adder among NUM_REQ requesters with round-robin issue and tagged returns.
// Optional per-requester grant counters are built when ADDER_ARB_STATS_EN is defined.
//
// state | meaning
// HALT  | quiesced, no grants, idle = 1
// RUN   | granting one request per cycle
// DRAIN | no new grants, waiting for in-flight results to return
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NUM_REQ = ARB_NUM_REQ_DEF,
  parameter  int WIDTH   = ARB_WIDTH_DEF,
  parameter  int ADD_LAT = ARB_ADD_LAT_DEF,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_en,
  output logic                     idle,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_cout,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_cout,
  output logic [IDW-1:0]           resp_id
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    stat_grants
`endif
);

  arb_state_t         r_state;
  logic               r_idle;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     w_next_ptr;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_any;
  logic               w_run;
  logic               w_busy;

  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic               w_sel_cin;
  logic [WIDTH-1:0]   r_add_a;
  logic [WIDTH-1:0]   r_add_b;
  logic               r_add_cin;

  arb_tag_t           r_issue;
  arb_tag_t           r_tag [ADD_LAT+1];
  logic [NUM_REQ-1:0] w_resp_onehot;

  logic [NUM_REQ-1:0] r_resp_valid;
  logic [WIDTH-1:0]   r_resp_sum;
  logic               r_resp_cout;
  logic [IDW-1:0]     r_resp_id;

  // cfg_en gates the grant directly so a request in the cycle cfg_en falls is not taken.
  assign w_run = (r_state == RUN) && cfg_en;
  assign w_req = req_valid & {NUM_REQ{w_run}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_req      (w_req),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_next_ptr (w_next_ptr),
    .o_any      (w_any)
  );

  assign req_ready = w_grant;

  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_a   = w_sel_a | ({WIDTH{w_grant[i]}} & req_a[i*WIDTH +: WIDTH]);
      w_sel_b   = w_sel_b | ({WIDTH{w_grant[i]}} & req_b[i*WIDTH +: WIDTH]);
      w_sel_cin = w_sel_cin | (w_grant[i] & req_cin[i]);
    end
  end

  always_comb begin
    w_busy = r_issue.valid;
    for (int k = 0; k <= ADD_LAT; k++) begin
      w_busy = w_busy | r_tag[k].valid;
    end
  end

  always_comb begin
    w_resp_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_tag[ADD_LAT].id == ARB_ID_W'(i)) begin
        w_resp_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= HALT;
      r_idle  <= 1'b1;
    end else begin
      case (r_state)
        HALT: begin
          if (cfg_en) begin
            r_state <= RUN;
            r_idle  <= 1'b0;
          end
        end
        RUN: begin
          if (!cfg_en) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (cfg_en) begin
            r_state <= RUN;
          end else if (!w_busy) begin
            r_state <= HALT;
            r_idle  <= 1'b1;
          end
        end
        default: begin
          r_state <= HALT;
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

  // The adder samples add_* on the edge after issue, so the tag waits one stage in r_issue
  // before entering the ADD_LAT+1 deep pipeline that lines up with add_sum/add_cout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr     <= IDW'(NUM_REQ - 1);
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_cin <= 1'b0;
      r_issue   <= '0;
      for (int k = 0; k <= ADD_LAT; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      r_issue.valid <= w_any;
      r_issue.id    <= ARB_ID_W'(w_next_ptr);
      if (w_any) begin
        r_ptr     <= w_next_ptr;
        r_add_a   <= w_sel_a;
        r_add_b   <= w_sel_b;
        r_add_cin <= w_sel_cin;
      end
      r_tag[0] <= r_issue;
      for (int k = 1; k <= ADD_LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= '0;
      r_resp_sum   <= '0;
      r_resp_cout  <= 1'b0;
      r_resp_id    <= '0;
    end else begin
      r_resp_valid <= '0;
      if (r_tag[ADD_LAT].valid) begin
        r_resp_valid <= w_resp_onehot;
        r_resp_sum   <= add_sum;
        r_resp_cout  <= add_cout;
        r_resp_id    <= r_tag[ADD_LAT].id[IDW-1:0];
      end
    end
  end

  assign idle       = r_idle;
  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign add_cin    = r_add_cin;
  assign resp_valid = r_resp_valid;
  assign resp_sum   = r_resp_sum;
  assign resp_cout  = r_resp_cout;
  assign resp_id    = r_resp_id;

`ifdef ADDER_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    logic [15:0] r_cnt;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
      end else if (w_grant[gi] && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign stat_grants[gi*16 +: 16] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural pipelined adder (NUM_REQ=4, ADD_LAT=4).
module tb_adder_arbiter;
  localparam int NR  = 4;
  localparam int W   = 16;
  localparam int LAT = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            cfg_en = 1'b0;
  logic            idle;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_a = '0;
  logic [NR*W-1:0] req_b = '0;
  logic [NR-1:0]   req_cin = '0;
  logic [W-1:0]    add_a, add_b, add_sum, resp_sum;
  logic            add_cin, add_cout, resp_cout;
  logic [NR-1:0]   resp_valid;
  logic [1:0]      resp_id;
`ifdef ADDER_ARB_STATS_EN
  logic [NR*16-1:0] stat_grants;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  adder_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ADD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .cfg_en(cfg_en), .idle(idle),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_id(resp_id)
`ifdef ADDER_ARB_STATS_EN
    , .stat_grants(stat_grants)
`endif
  );

  always #5 clk = ~clk;

  // Adder model: input register plus LAT stages, never reset (stale data must be ignored).
  logic [W:0] pipe [0:LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    for (int k = 1; k <= LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign add_sum  = pipe[LAT][W-1:0];
  assign add_cout = pipe[LAT][W];

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t        vecs [6];
  logic [16:0] exp_f [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_idle"}, 32'(idle), 32'd1);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_add_a"}, 32'(add_a), 32'd0);
    check({tag, "_add_b"}, 32'(add_b), 32'd0);
    check({tag, "_add_cin"}, 32'(add_cin), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_sum"}, 32'(resp_sum), 32'd0);
    check({tag, "_resp_cout"}, 32'(resp_cout), 32'd0);
    check({tag, "_resp_id"}, 32'(resp_id), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; cfg_en = 1'b0; req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cfg_en = 1'b1;
    @(negedge clk);
    check("run_after_enable_idle", 32'(idle), 32'd0);
  endtask

  task automatic single(input vec_t v);
    int          lat;
    bit          got;
    logic [3:0]  one;
    one = 4'b0001 << v.id;
    lat = -1;
    got = 1'b0;
    @(negedge clk);
    req_a[v.id*W +: W] = v.a;
    req_b[v.id*W +: W] = v.b;
    req_cin[v.id]      = v.cin;
    req_valid          = one;
    #1;
    check("single_ready", 32'(req_ready), 32'(one));
    @(posedge clk);
    #1 req_valid = '0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        got = 1'b1;
        lat = c;
      end
    end
    check("single_latency", 32'(lat), 32'(LAT + 2));
    if (got) begin
      check("single_resp_valid", 32'(resp_valid), 32'(one));
      check("single_sum", 32'(resp_sum), 32'(v.sum));
      check("single_cout", 32'(resp_cout), 32'(v.cout));
      check("single_id", 32'(resp_id), 32'(v.id));
      @(negedge clk);
      check("single_pulse_width", 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_ready;
    logic [3:0] exp_rv;

    vecs[0] = '{0, 16'h1234, 16'h0F0F, 1'b1, 16'h2144, 1'b0};
    vecs[1] = '{2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{3, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{3, 16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0};
    // requester i: a = 16'h4000*i, b = 16'hC000, cin = i[0]
    exp_f[0] = 17'h0C000;
    exp_f[1] = 17'h10001;
    exp_f[2] = 17'h14000;
    exp_f[3] = 17'h18001;

    reset = 1'b0;
    req_valid = 4'hF;
    #12;
    check_reset_vals("reset");
    do_reset();

    for (int i = 0; i < 6; i++) single(vecs[i]);

    // Fairness: all four requesters held valid for 8 cycles from a fresh pointer.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_a[i*W +: W] = 16'h4000 * i[15:0];
      req_b[i*W +: W] = 16'hC000;
      req_cin[i]      = i[0];
    end
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      exp_ready = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      check("fair_ready", 32'(req_ready), 32'(exp_ready));
      exp_rv = (k >= 7 && k <= 14) ? (4'b0001 << ((k - 7) % 4)) : 4'b0000;
      check("fair_resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (k >= 7 && k <= 14) begin
        check("fair_resp_id", 32'(resp_id), 32'((k - 7) % 4));
        check("fair_resp_sum", 32'({resp_cout, resp_sum}), 32'(exp_f[(k - 7) % 4]));
      end
    end
`ifdef ADDER_ARB_STATS_EN
    for (int i = 0; i < NR; i++) check("stat_grants", 32'(stat_grants[i*16 +: 16]), 32'd2);
`endif

    // Drain with three in flight, then resume.
    for (int k = 0; k <= 23; k++) begin
      @(negedge clk);
      if (k < 3) req_valid = 4'b0111;
      if (k == 3) cfg_en = 1'b0;
      if (k == 15) cfg_en = 1'b1;
      if (k == 17) req_valid = 4'b0000;
      #1;
      exp_ready = (k < 3) ? (4'b0001 << k) : ((k == 16) ? 4'b0001 : 4'b0000);
      check("drain_ready", 32'(req_ready), 32'(exp_ready));
      exp_rv = (k >= 7 && k <= 9) ? (4'b0001 << (k - 7)) : ((k == 23) ? 4'b0001 : 4'b0000);
      check("drain_resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (k >= 7 && k <= 9)
        check("drain_resp_sum", 32'({resp_cout, resp_sum}), 32'(exp_f[k - 7]));
      if (k == 23)
        check("resume_resp_sum", 32'({resp_cout, resp_sum}), 32'(exp_f[0]));
      if (k >= 4 && k <= 15)
        check("drain_idle", 32'(idle), (k >= 10) ? 32'd1 : 32'd0);
    end

    // Reset with two operations in flight.
    @(negedge clk);
    req_valid = 4'b0011;
    repeat (2) @(negedge clk);
    req_valid = 4'hF;
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    req_valid = '0;
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("midrst_no_resp", 32'(resp_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
